// File: rtl/mem_stage_pipe.sv
// Memory stage: byte/half/word loads and stores over a variable-latency memory port,
// result held in an output register for WB. Optional build macro: MEM_ALIGN_CHECK_EN.
module mem_stage_pipe #(
    parameter int ADDR_W  = 32,
    parameter int SIDE_W  = 96,
    parameter int REGNO_W = 5
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_op,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic [31:0]        in_wdata,
    input  logic [REGNO_W-1:0] in_rd,
    input  logic               in_wr_reg,
    input  logic [SIDE_W-1:0]  in_side,

    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic               mem_req_we,
    output logic [ADDR_W-1:0]  mem_req_addr,
    output logic [31:0]        mem_req_wdata,
    output logic [3:0]         mem_req_be,
    input  logic               mem_rsp_valid,
    input  logic [31:0]        mem_rsp_rdata,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_result,
    output logic [REGNO_W-1:0] out_rd,
    output logic               out_wr_reg,
    output logic [SIDE_W-1:0]  out_side,
    output logic               out_misalign,

    output logic [REGNO_W-1:0] fwd_rd,
    output logic               fwd_load_busy
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd9;
    localparam logic [3:0] OP_SH  = 4'd10;
    localparam logic [3:0] OP_SW  = 4'd11;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_is_byte(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    endfunction

    function automatic logic op_is_half(input logic [3:0] op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    // Byte lane of the access: halfwords snap to addr[1], words always use lane 0,
    // so low address bits never matter when alignment is not enforced.
    function automatic logic [1:0] lane_of(input logic [3:0] op, input logic [1:0] lo);
        if (op_is_byte(op))
            return lo;
        else if (op_is_half(op))
            return {lo[1], 1'b0};
        else
            return 2'b00;
    endfunction

    function automatic logic [3:0] be_of(input logic [3:0] op, input logic [1:0] lane);
        if (!op_is_store(op))
            return 4'b1111;
        else if (op_is_byte(op))
            return 4'b0001 << lane;
        else if (op_is_half(op))
            return 4'b0011 << lane;
        else
            return 4'b1111;
    endfunction

    function automatic logic [31:0] wdata_of(input logic [3:0] op, input logic [31:0] d);
        if (op_is_byte(op))
            return {4{d[7:0]}};
        else if (op_is_half(op))
            return {2{d[15:0]}};
        else
            return d;
    endfunction

    function automatic logic [31:0] extend(input logic [3:0] op, input logic [31:0] word,
                                           input logic [1:0] lane);
        logic [31:0] s;
        s = word >> {lane, 3'b000};
        case (op)
            OP_LB:   return {{24{s[7]}}, s[7:0]};
            OP_LBU:  return {24'd0, s[7:0]};
            OP_LH:   return {{16{s[15]}}, s[15:0]};
            OP_LHU:  return {16'd0, s[15:0]};
            default: return s;
        endcase
    endfunction

    state_t              state_reg;
    logic [3:0]          op_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [1:0]          lane_reg;
    logic [REGNO_W-1:0]  rd_reg;
    logic                wr_reg_reg;
    logic [SIDE_W-1:0]   side_reg;

    logic                accept;
    logic                in_is_load;
    logic                in_is_store;
    logic                in_misaligned;
    logic [1:0]          in_lane;

    assign in_ready    = (state_reg == IDLE) && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign in_is_load  = op_is_load(in_op);
    assign in_is_store = op_is_store(in_op);
    assign in_lane     = lane_of(in_op, in_addr[1:0]);

`ifdef MEM_ALIGN_CHECK_EN
    assign in_misaligned = (op_is_half(in_op) && in_addr[0]) ||
                           ((in_op == OP_LW || in_op == OP_SW) && (in_addr[1:0] != 2'b00));
`else
    assign in_misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            op_reg        <= '0;
            addr_reg      <= '0;
            lane_reg      <= '0;
            rd_reg        <= '0;
            wr_reg_reg    <= 1'b0;
            side_reg      <= '0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_be    <= '0;
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_rd        <= '0;
            out_wr_reg    <= 1'b0;
            out_side      <= '0;
            out_misalign  <= 1'b0;
            fwd_rd        <= '0;
            fwd_load_busy <= 1'b0;
        end else begin
            // Drain first; any write below in the same cycle takes priority.
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (!in_is_load && !in_is_store) begin
                            out_valid    <= 1'b1;
                            out_result   <= 32'(in_addr);
                            out_rd       <= in_rd;
                            out_wr_reg   <= in_wr_reg;
                            out_side     <= in_side;
                            out_misalign <= 1'b0;
                        end else if (in_misaligned) begin
                            out_valid    <= 1'b1;
                            out_result   <= 32'(in_addr);
                            out_rd       <= in_rd;
                            out_wr_reg   <= 1'b0;
                            out_side     <= in_side;
                            out_misalign <= 1'b1;
                        end else begin
                            op_reg        <= in_op;
                            addr_reg      <= in_addr;
                            lane_reg      <= in_lane;
                            rd_reg        <= in_rd;
                            wr_reg_reg    <= in_wr_reg;
                            side_reg      <= in_side;
                            mem_req_valid <= 1'b1;
                            mem_req_we    <= in_is_store;
                            mem_req_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
                            mem_req_wdata <= wdata_of(in_op, in_wdata);
                            mem_req_be    <= be_of(in_op, in_lane);
                            if (in_is_load)
                                fwd_rd <= in_rd;
                            fwd_load_busy <= in_is_load && in_wr_reg;
                            state_reg     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        if (op_is_store(op_reg)) begin
                            out_valid    <= 1'b1;
                            out_result   <= 32'(addr_reg);
                            out_rd       <= rd_reg;
                            out_wr_reg   <= wr_reg_reg;
                            out_side     <= side_reg;
                            out_misalign <= 1'b0;
                            state_reg    <= IDLE;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        out_valid     <= 1'b1;
                        out_result    <= extend(op_reg, mem_rsp_rdata, lane_reg);
                        out_rd        <= rd_reg;
                        out_wr_reg    <= wr_reg_reg;
                        out_side      <= side_reg;
                        out_misalign  <= 1'b0;
                        fwd_load_busy <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: vector table of single transactions plus
// hand-written sequences for stalls, back-pressure, misalignment and mid-access reset.
module tb_mem_stage_pipe;
    localparam int ADDR_W  = 32;
    localparam int SIDE_W  = 96;
    localparam int REGNO_W = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         in_op;
    logic [ADDR_W-1:0]  in_addr;
    logic [31:0]        in_wdata;
    logic [REGNO_W-1:0] in_rd;
    logic               in_wr_reg;
    logic [SIDE_W-1:0]  in_side;
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic               mem_req_we;
    logic [ADDR_W-1:0]  mem_req_addr;
    logic [31:0]        mem_req_wdata;
    logic [3:0]         mem_req_be;
    logic               mem_rsp_valid;
    logic [31:0]        mem_rsp_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_result;
    logic [REGNO_W-1:0] out_rd;
    logic               out_wr_reg;
    logic [SIDE_W-1:0]  out_side;
    logic               out_misalign;
    logic [REGNO_W-1:0] fwd_rd;
    logic               fwd_load_busy;

    mem_stage_pipe #(.ADDR_W(ADDR_W), .SIDE_W(SIDE_W), .REGNO_W(REGNO_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_rd(in_rd), .in_wr_reg(in_wr_reg), .in_side(in_side),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
        .out_wr_reg(out_wr_reg), .out_side(out_side), .out_misalign(out_misalign),
        .fwd_rd(fwd_rd), .fwd_load_busy(fwd_load_busy)
    );

    always #5 clk = ~clk;

    // kind: 0 = non-memory, 1 = load, 2 = store
    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_word;
        int          kind;
        logic [31:0] exp_result;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[14];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [SIDE_W-1:0] act, input logic [SIDE_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] word, input int kind, input logic [31:0] res,
                                input logic [3:0] be, input logic [31:0] ewd);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.mem_word = word; v.kind = kind;
        v.exp_result = res; v.exp_be = be; v.exp_wdata = ewd;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
    endtask

    task automatic present(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [4:0] rd, input logic wr, input logic [95:0] side);
        in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wdata;
        in_rd = rd; in_wr_reg = wr; in_side = side;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        logic [4:0]  rd;
        logic [95:0] side;
        rd   = 5'(i + 3);
        side = {32'(i), 64'hA5A5_0000_1234_5678};
        wait_in_ready();
        present(v.op, v.addr, v.wdata, rd, v.kind != 2, side);
        step();
        in_valid = 1'b0;
        if (v.kind != 0) begin
            chk("req_valid", mem_req_valid, 1);
            chk("req_addr", mem_req_addr, {v.addr[31:2], 2'b00});
            chk("req_be", mem_req_be, v.exp_be);
            chk("req_we", mem_req_we, v.kind == 2);
            chk("out_valid_busy", out_valid, 0);
            if (v.kind == 2) chk("req_wdata", mem_req_wdata, v.exp_wdata);
            if (v.kind == 1) begin
                chk("fwd_busy_req", fwd_load_busy, 1);
                chk("fwd_rd", fwd_rd, rd);
            end
            step();
            if (v.kind == 1) begin
                chk("fwd_busy_wait", fwd_load_busy, 1);
                chk("req_valid_wait", mem_req_valid, 0);
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = v.mem_word;
                step();
                mem_rsp_valid = 1'b0;
                mem_rsp_rdata = 32'hDEAD_0000;
                chk("fwd_busy_done", fwd_load_busy, 0);
            end
        end
        chk("out_valid", out_valid, 1);
        chk("out_result", out_result, v.exp_result);
        chk("out_rd", out_rd, rd);
        chk("out_wr_reg", out_wr_reg, v.kind != 2);
        chk("out_side", out_side, side);
        chk("out_misalign", out_misalign, 0);
        $display("[TB] txn %0d op=%0d addr=0x%08h result=0x%08h expected=0x%08h",
                 i, v.op, v.addr, out_result, v.exp_result);
    endtask

    initial begin
        vecs[0]  = mk(4'd3,  32'h100,      32'h0,        32'h8899AABB, 1, 32'h8899AABB, 4'hF, 32'h0);
        vecs[1]  = mk(4'd1,  32'h103,      32'h0,        32'h80FF0102, 1, 32'hFFFFFF80, 4'hF, 32'h0);
        vecs[2]  = mk(4'd4,  32'h103,      32'h0,        32'h80FF0102, 1, 32'h00000080, 4'hF, 32'h0);
        vecs[3]  = mk(4'd2,  32'h102,      32'h0,        32'h80FF0102, 1, 32'hFFFF80FF, 4'hF, 32'h0);
        vecs[4]  = mk(4'd5,  32'h100,      32'h0,        32'h80FF0102, 1, 32'h00000102, 4'hF, 32'h0);
        vecs[5]  = mk(4'd1,  32'h101,      32'h0,        32'h80FF0102, 1, 32'h00000001, 4'hF, 32'h0);
        vecs[6]  = mk(4'd1,  32'h102,      32'h0,        32'h80FF0102, 1, 32'hFFFFFFFF, 4'hF, 32'h0);
        vecs[7]  = mk(4'd5,  32'h102,      32'h0,        32'h80FF0102, 1, 32'h000080FF, 4'hF, 32'h0);
        vecs[8]  = mk(4'd9,  32'h201,      32'h000000A5, 32'h0,        2, 32'h00000201, 4'h2, 32'hA5A5A5A5);
        vecs[9]  = mk(4'd10, 32'h100,      32'h00005A5A, 32'h0,        2, 32'h00000100, 4'h3, 32'h5A5A5A5A);
        vecs[10] = mk(4'd11, 32'h204,      32'hDEADBEEF, 32'h0,        2, 32'h00000204, 4'hF, 32'hDEADBEEF);
        vecs[11] = mk(4'd0,  32'h12345678, 32'h0,        32'h0,        0, 32'h12345678, 4'h0, 32'h0);
        vecs[12] = mk(4'd7,  32'hCAFE0000, 32'h0,        32'h0,        0, 32'hCAFE0000, 4'h0, 32'h0);
        vecs[13] = mk(4'd15, 32'h00000ABC, 32'h0,        32'h0,        0, 32'h00000ABC, 4'h0, 32'h0);

        reset = 1'b0;
        in_valid = 1'b0; in_op = '0; in_addr = '0; in_wdata = '0; in_rd = '0; in_wr_reg = 1'b0; in_side = '0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'hDEAD_0000; out_ready = 1'b1;
        repeat (3) step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_fwd_busy", fwd_load_busy, 0);
        reset = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // SH with memory stalling three cycles
        wait_in_ready();
        present(4'd10, 32'h102, 32'h1234ABCD, 5'd7, 1'b0, 96'h1);
        mem_req_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("sh_req_valid", mem_req_valid, 1);
            chk("sh_req_be", mem_req_be, 4'b1100);
            chk("sh_req_wdata", mem_req_wdata, 32'hABCDABCD);
            chk("sh_req_addr", mem_req_addr, 32'h100);
            chk("sh_req_we", mem_req_we, 1);
            chk("sh_in_ready", in_ready, 0);
            if (c < 2) step();
        end
        mem_req_ready = 1'b1;
        step();
        chk("sh_out_valid", out_valid, 1);
        chk("sh_out_result", out_result, 32'h102);
        chk("sh_req_done", mem_req_valid, 0);
        $display("[TB] txn SH-stall result=0x%08h", out_result);

        // NONE under WB back-pressure; second NONE only accepted on the drain cycle
        step();
        wait_in_ready();
        present(4'd0, 32'hAAAA0001, 32'h0, 5'd1, 1'b1, 96'h2);
        step();
        present(4'd0, 32'hBBBB0002, 32'h0, 5'd2, 1'b1, 96'h3);
        out_ready = 1'b0;
        #1;
        for (int c = 0; c < 2; c++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_result", out_result, 32'hAAAA0001);
            chk("bp_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_drain_in_ready", in_ready, 1);
        chk("bp_drain_result", out_result, 32'hAAAA0001);
        step();
        in_valid = 1'b0;
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_result", out_result, 32'hBBBB0002);
        $display("[TB] txn NONE-backpressure result=0x%08h", out_result);
        step();
        chk("bp_cleared", out_valid, 0);

        // Misaligned LW
        wait_in_ready();
        present(4'd3, 32'h101, 32'h0, 5'd9, 1'b1, 96'h4);
        step();
        in_valid = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_req_valid", mem_req_valid, 0);
        chk("mis_out_valid", out_valid, 1);
        chk("mis_flag", out_misalign, 1);
        chk("mis_wr_reg", out_wr_reg, 0);
        chk("mis_result", out_result, 32'h101);
`else
        chk("mis_req_valid", mem_req_valid, 1);
        chk("mis_req_addr", mem_req_addr, 32'h100);
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h11223344;
        step();
        mem_rsp_valid = 1'b0;
        chk("mis_out_valid", out_valid, 1);
        chk("mis_flag", out_misalign, 0);
        chk("mis_result", out_result, 32'h11223344);
`endif
        $display("[TB] txn LW-misaligned result=0x%08h misalign=%0d", out_result, out_misalign);
        step();

        // Reset during WAIT, late response must be dropped
        wait_in_ready();
        present(4'd3, 32'h300, 32'h0, 5'd11, 1'b1, 96'h5);
        step();
        in_valid = 1'b0;
        step();
        chk("rw_fwd_busy_wait", fwd_load_busy, 1);
        reset = 1'b0;
        #1;
        chk("rw_fwd_busy_rst", fwd_load_busy, 0);
        chk("rw_req_valid_rst", mem_req_valid, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        step();
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h55667788;
        step();
        mem_rsp_valid = 1'b0;
        chk("rw_out_valid", out_valid, 0);
        chk("rw_in_ready", in_ready, 1);
        chk("rw_req_valid", mem_req_valid, 0);
        $display("[TB] txn reset-in-WAIT out_valid=%0d in_ready=%0d", out_valid, in_ready);

        run_vec(99, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_stage_pipe.md
# mem_stage_pipe

Parametrised successor of the pipeline's memory stage. Accepts one instruction at a time from AGEX over a valid/ready handshake and performs byte, halfword or word loads and stores with sign or zero extension. Talks to a variable-latency data memory over a request/response port and holds its result in an output register until WB takes it. Stalls upstream while an access is outstanding and exposes a load-pending hazard signal to DE.

## Interface
- `ADDR_W`, 32: byte-address width.
- `SIDE_W`, 96: width of the opaque sideband bundle (inst, PC, inst_count, canary) carried through unchanged.
- `REGNO_W`, 5: destination register number width.
- `clk`  in  1: the single clock. One clock; reset is asynchronous and active-low.
- `reset`  in  1: asynchronous, active-low; clears all state.
- `in_valid`  in  1: AGEX presents an instruction.
- `in_ready`  out  1: stage accepts this cycle.
- `in_op`  in  4: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 9 SB, 10 SH, 11 SW; any other code is treated as NONE.
- `in_addr`  in  ADDR_W: ALU result; the memory address for memory ops.
- `in_wdata`  in  32: store data, right-aligned.
- `in_rd`  in  REGNO_W, `in_wr_reg` in 1, `in_side` in SIDE_W: passed through.
- `mem_req_valid`/`mem_req_ready`  out/in  1: request handshake.
- `mem_req_we`  out  1, `mem_req_addr` out ADDR_W (low 2 bits zero), `mem_req_wdata` out 32 (lane-replicated), `mem_req_be` out 4.
- `mem_rsp_valid`  in  1, `mem_rsp_rdata` in 32: load response, full word.
- `out_valid`/`out_ready`  out/in  1: result handshake to WB.
- `out_result` out 32, `out_rd` out REGNO_W, `out_wr_reg` out 1, `out_side` out SIDE_W, `out_misalign` out 1.
- `fwd_rd`  out  REGNO_W, `fwd_load_busy` out 1: a load to `fwd_rd` with `wr_reg`=1 is in REQ or WAIT.

## Operation
- FSM states are IDLE, REQ and WAIT.
- `in_ready` = (state==IDLE) && (!out_valid || out_ready).
- IDLE, accept of NONE: the output register loads `in_addr` as the result; state stays IDLE.
- IDLE, accept of a memory op: capture all inputs and go to REQ. A misaligned op (LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0) is handled per Configuration.
- REQ: `mem_req_valid`=1.
  - SB: be=0001<<addr[1:0], wdata = byte replicated 4×.
  - SH: be=0011<<addr[1:0], wdata = halfword replicated 2×.
  - SW: be=1111.
  - Loads: we=0, be=1111.
  - On `mem_req_ready`, a store writes the output register (result = address) and returns to IDLE; a load goes to WAIT.
- WAIT: on `mem_rsp_valid`, select the lane at addr[1:0], sign-extend (LB/LH) or zero-extend (LBU/LHU), write the output register, return to IDLE.
- `mem_rsp_valid` outside WAIT is ignored.
- The output register clears when `out_valid && out_ready` and nothing new is written that cycle.
- Reset values: every output 0, state IDLE, output register empty.
- Reset asserted mid-REQ/WAIT aborts the access. A response arriving after reset releases is dropped.

## Timing
- NONE: accepted at edge N, `out_valid` from N+1.
- Store: accepted at N, request at N+1. With `mem_req_ready`=1, `out_valid` from N+2.
- Load: accepted at N, request at N+1, response no earlier than N+2, `out_valid` from the cycle after the response (minimum N+3).
- Request signals hold stable while `mem_req_valid && !mem_req_ready`.
- The output register holds stable while `out_valid && !out_ready`. Back-pressure blocks `in_ready`.
- `fwd_load_busy` is registered and asserts the cycle after a load is accepted.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: a misaligned memory op issues no request. The stage writes the output register at N+1 with `out_misalign`=1, `out_wr_reg`=0 and result = address.
- Not defined: address low bits are ignored for alignment. Halfword ops use addr[1], word ops use lane 0, and `out_misalign` is tied 0.

## Test plan
- LW at 0x100, memory word 0x8899AABB, `mem_req_ready`=1, response 1 cycle after request -> `out_result`=0x8899AABB at N+3, `fwd_load_busy` high N+1..N+2.
- LB at 0x103 and LBU at 0x103 over word 0x80FF0102 -> 0xFFFFFF80 and 0x00000080.
- SH at 0x102, wdata 0x1234ABCD -> be=1100, `mem_req_wdata`=0xABCDABCD, we=1; `mem_req_ready` held low 3 cycles -> request stable, `in_ready`=0 throughout.
- NONE op with `out_ready`=0 for 2 cycles, then 1 -> `out_valid` held with stable result; second NONE accepted only on the drain cycle.
- LW at 0x101: with `MEM_ALIGN_CHECK_EN` -> no request, `out_misalign`=1 at N+1; without it -> request to 0x100.
- Reset low during WAIT, then a response arrives after release -> `out_valid` stays 0, state IDLE, `in_ready`=1.
